// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared direction/state types and default timing constants
package input_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DELAY  = 2'b01,
    REPEAT = 2'b10
  } rep_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 65000;
  localparam int DEF_REPEAT_DELAY    = 12;
  localparam int DEF_REPEAT_RATE     = 6;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchroniser plus consecutive-disagreement debouncer
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = input_pkg::DEF_DEBOUNCE_CYCLES
) (
  input  logic vclk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge vclk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // any cycle of agreement throws away the partial count
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/direction_request_gen.sv
// rtl/direction_request_gen.sv - debounced joypad to frame-aligned one-hot step requests
module direction_request_gen
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic        vclk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic [1:0]  facing
);

  localparam int FMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int FW   = $clog2(FMAX + 1);

  logic [3:0] w_raw;
  logic [3:0] w_deb;
  logic       w_tick;
  logic       w_u, w_d, w_l, w_r;
  logic       w_sel_valid;
  dir_t       w_sel;
  logic       w_restart;
  logic       w_due;
  logic       w_emit;

  rep_state_t    r_state;
  dir_t          r_cur_dir;
  logic [FW-1:0] r_fcnt;
  logic          r_up, r_down, r_left, r_right;
  dir_t          r_facing;

  assign w_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .vclk    (vclk),
      .reset   (reset),
      .i_btn   (w_raw[g]),
      .o_level (w_deb[g])
    );
  end

  assign w_tick = (hcount == 11'd0) && (vcount == 10'd0);

  // opposing pairs cancel before the fixed up > down > left > right priority
  always_comb begin
    w_u = w_deb[0] & ~w_deb[1];
    w_d = w_deb[1] & ~w_deb[0];
    w_l = w_deb[2] & ~w_deb[3];
    w_r = w_deb[3] & ~w_deb[2];
    w_sel_valid = w_u | w_d | w_l | w_r;
    w_sel = w_u ? DIR_UP : w_d ? DIR_DOWN : w_l ? DIR_LEFT : DIR_RIGHT;
    w_restart = w_sel_valid && ((r_state == IDLE) || (w_sel != r_cur_dir));
    w_due = w_sel_valid && !w_restart &&
            (((r_state == DELAY)  && (r_fcnt == FW'(REPEAT_DELAY))) ||
             ((r_state == REPEAT) && (r_fcnt == FW'(REPEAT_RATE))));
    w_emit = w_restart | w_due;
  end

  always_ff @(posedge vclk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cur_dir <= DIR_DOWN;
      r_fcnt    <= '0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_facing  <= DIR_DOWN;
    end else if (w_tick) begin
      r_up    <= w_emit && (w_sel == DIR_UP);
      r_down  <= w_emit && (w_sel == DIR_DOWN);
      r_left  <= w_emit && (w_sel == DIR_LEFT);
      r_right <= w_emit && (w_sel == DIR_RIGHT);
      if (w_emit) r_facing <= w_sel;
      if (!w_sel_valid) begin
        r_state <= IDLE;
      end else if (w_restart) begin
        r_cur_dir <= w_sel;
        r_fcnt    <= FW'(1);
        r_state   <= DELAY;
      end else if (w_due) begin
        r_fcnt  <= FW'(1);
        r_state <= REPEAT;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign up     = r_up;
  assign down   = r_down;
  assign left   = r_left;
  assign right  = r_right;
  assign facing = r_facing;

endmodule
